// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, keymap and helpers
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

   localparam logic [3:0] CODE_STAR = 4'hE;
   localparam logic [3:0] CODE_HASH = 4'hF;
   localparam logic [3:0] COL_RESET = 4'b1110;

   // indexed by {row, col}
   localparam logic [3:0] KEYMAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      CODE_STAR, 4'h0, CODE_HASH, 4'hD
   };

   function automatic logic [1:0] low_row(input logic [3:0] rows);
      if (!rows[0])      low_row = 2'd0;
      else if (!rows[1]) low_row = 2'd1;
      else if (!rows[2]) low_row = 2'd2;
      else               low_row = 2'd3;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      col_drive = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-FF synchronizer for the active-low row inputs,
// idling at "no key" (all ones).
module keypad_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_d,
   output logic [3:0] o_q
);

   logic [3:0] r_meta;
   logic [3:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 4'hF;
         r_sync <= 4'hF;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with press/release debounce
// and a two-digit BCD entry register.
module keypad_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ROW,
   output logic [3:0] COLUMN,
   output logic       KEY_VALID,
   output logic [3:0] KEY_CODE,
   output logic [3:0] KB1,
   output logic [3:0] KB0
);

   import keypad_pkg::*;

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);
   localparam bit ONE_SHOT = (DEBOUNCE_CNT == 1);

   state_t        r_state;
   logic [DW-1:0] r_div;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_col;
   logic [1:0]    r_row;

   logic [3:0]    w_rows;
   logic          w_tick;
   logic          w_any;
   logic [CW-1:0] w_cnt_nx;
   logic [1:0]    w_col_nx;
   logic [1:0]    w_key_row;
   logic [3:0]    w_code;
   logic          w_accept;

   keypad_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (ROW),
      .o_q   (w_rows)
   );

   assign w_tick    = (r_div == DIV_LAST);
   assign w_any     = (w_rows != 4'hF);
   assign w_cnt_nx  = r_cnt + 1'b1;
   assign w_col_nx  = r_col + 2'd1;
   assign w_key_row = (r_state == SCAN) ? low_row(w_rows) : r_row;
   assign w_code    = KEYMAP[{w_key_row, r_col}];

   // a single-sample debounce accepts straight from the detection tick
   assign w_accept = w_tick &&
      ((r_state == SCAN && w_any && ONE_SHOT) ||
       (r_state == DEBOUNCE && !w_rows[r_row] &&
        w_cnt_nx == CNT_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SCAN;
         r_div     <= '0;
         r_cnt     <= '0;
         r_col     <= 2'd0;
         r_row     <= 2'd0;
         COLUMN    <= COL_RESET;
         KEY_VALID <= 1'b0;
         KEY_CODE  <= 4'h0;
         KB1       <= 4'h0;
         KB0       <= 4'h0;
      end else begin
         KEY_VALID <= 1'b0;
         r_div     <= w_tick ? '0 : r_div + 1'b1;
         if (w_accept) begin
            KEY_VALID <= 1'b1;
            KEY_CODE  <= w_code;
            r_row     <= w_key_row;
            r_cnt     <= '0;
            r_state   <= HOLD;
            case (w_code)
               CODE_STAR: begin
                  KB1 <= 4'h0;
                  KB0 <= 4'h0;
               end
               CODE_HASH, 4'hA, 4'hB, 4'hC, 4'hD: ;
               default: begin
                  KB1 <= KB0;
                  KB0 <= w_code;
               end
            endcase
         end else if (w_tick) begin
            unique case (r_state)
               SCAN: begin
                  if (!w_any) begin
                     r_col  <= w_col_nx;
                     COLUMN <= col_drive(w_col_nx);
                  end else begin
                     r_row   <= w_key_row;
                     r_cnt   <= CW'(1);
                     r_state <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (!w_rows[r_row]) begin
                     r_cnt <= w_cnt_nx;
                  end else begin
                     r_cnt   <= '0;
                     r_col   <= w_col_nx;
                     COLUMN  <= col_drive(w_col_nx);
                     r_state <= SCAN;
                  end
               end
               HOLD: begin
                  if (w_any) begin
                     r_cnt <= '0;
                  end else if (w_cnt_nx == CNT_DONE) begin
                     r_cnt   <= '0;
                     r_col   <= w_col_nx;
                     COLUMN  <= col_drive(w_col_nx);
                     r_state <= SCAN;
                  end else begin
                     r_cnt <= w_cnt_nx;
                  end
               end
               default: r_state <= SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives a simulated 4x4 keypad into keypad_scan and
// checks accepted codes and the entry digits against a keypad-level model.
module tb_keypad_scan;

   localparam int SD = 4;
   localparam int DC = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] ROW;
   logic [3:0] COLUMN;
   logic       KEY_VALID;
   logic [3:0] KEY_CODE;
   logic [3:0] KB1;
   logic [3:0] KB0;

   int checks  = 0;
   int errors  = 0;
   int n_valid = 0;
   logic [3:0] last_code = 4'h0;

   logic key_on = 1'b0;
   int   key_r  = 0;
   int   key_c  = 0;

   int m_kb1 = 0;
   int m_kb0 = 0;

   // keypad face as printed: face[row][col]
   logic [3:0] face [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };
   logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   always #5 clk = ~clk;

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ROW       (ROW),
      .COLUMN    (COLUMN),
      .KEY_VALID (KEY_VALID),
      .KEY_CODE  (KEY_CODE),
      .KB1       (KB1),
      .KB0       (KB0)
   );

   // a pressed switch shorts its row to its column when that column is driven low
   always_comb begin
      ROW = 4'hF;
      if (key_on && COLUMN[key_c] == 1'b0) ROW[key_r] = 1'b0;
   end

   always @(posedge clk) begin
      #2;
      if (KEY_VALID === 1'b1) begin
         n_valid++;
         last_code = KEY_CODE;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_accept(input logic [3:0] code);
      if (code <= 4'h9) begin
         m_kb1 = m_kb0;
         m_kb0 = int'(code);
      end else if (code == 4'hE) begin
         m_kb1 = 0;
         m_kb0 = 0;
      end
   endtask

   task automatic press(input int r, input int c, input int hold);
      int base;
      base   = n_valid;
      key_r  = r;
      key_c  = c;
      key_on = 1'b1;
      cyc(hold);
      model_accept(face[r][c]);
      check("press_count", n_valid - base, 1);
      check("press_code", last_code, face[r][c]);
      check("kb1", KB1, m_kb1);
      check("kb0", KB0, m_kb0);
      key_on = 1'b0;
      base   = n_valid;
      cyc(40);
      check("release_quiet", n_valid - base, 0);
   endtask

   initial begin
      int base;
      bit ok;
      logic [3:0] prev;

      // 1: reset, async assert mid-cycle, then rotation order
      cyc(3);
      rst_n = 1'b1;
      cyc(10);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_column", COLUMN, 4'b1110);
      check("rst_valid", KEY_VALID, 1'b0);
      check("rst_code", KEY_CODE, 4'h0);
      check("rst_kb1", KB1, 4'h0);
      check("rst_kb0", KB0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         check("rotate", COLUMN, rot[((k + 1) / SD) % 4]);
      end

      // 2: '5' held long, exactly one code
      cyc(2);
      press(1, 1, 200);

      // 3: '7' then 'A'
      press(2, 0, 80);
      press(0, 3, 80);

      // 4: bounce on key '1' lasting two ticks
      ok   = 1'b0;
      prev = COLUMN;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (COLUMN == 4'b1110 && prev != 4'b1110) ok = 1'b1;
         prev = COLUMN;
      end
      check("bounce_align", ok, 1'b1);
      base   = n_valid;
      key_r  = 0;
      key_c  = 0;
      key_on = 1'b1;
      cyc(8);
      check("bounce_held", COLUMN, 4'b1110);
      cyc(1);
      key_on = 1'b0;
      cyc(3);
      check("bounce_col1", COLUMN, 4'b1101);
      check("bounce_novalid", n_valid - base, 0);
      cyc(4);
      check("bounce_col2", COLUMN, 4'b1011);

      // 5: '*' clears the entry
      press(3, 0, 80);

      // 6: reset while a held '9' sits in HOLD
      base   = n_valid;
      key_r  = 2;
      key_c  = 2;
      key_on = 1'b1;
      cyc(60);
      check("hold9_count", n_valid - base, 1);
      #3;
      rst_n = 1'b0;
      #1;
      m_kb1 = 0;
      m_kb0 = 0;
      check("hrst_column", COLUMN, 4'b1110);
      check("hrst_valid", KEY_VALID, 1'b0);
      check("hrst_code", KEY_CODE, 4'h0);
      check("hrst_kb0", KB0, 4'h0);
      cyc(2);
      base  = n_valid;
      rst_n = 1'b1;
      cyc(60);
      model_accept(face[2][2]);
      check("reacc_count", n_valid - base, 1);
      check("reacc_code", last_code, face[2][2]);
      check("reacc_kb1", KB1, m_kb1);
      check("reacc_kb0", KB0, m_kb0);
      key_on = 1'b0;
      cyc(40);

      // random glitches followed by real presses
      for (int n = 0; n < 12; n++) begin
         int r;
         int c;
         r      = int'($urandom_range(0, 3));
         c      = int'($urandom_range(0, 3));
         base   = n_valid;
         key_r  = int'($urandom_range(0, 3));
         key_c  = int'($urandom_range(0, 3));
         key_on = 1'b1;
         cyc(int'($urandom_range(1, 3)));
         key_on = 1'b0;
         cyc(20);
         check("glitch_quiet", n_valid - base, 0);
         press(r, c, int'($urandom_range(50, 120)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
